// File: rtl/smg_scan_mux.sv
// Multiplexed seven-segment scan controller with per-digit blanking, 8-level brightness and a frame tick.
// Define SMG_SCAN_DEADTIME_EN to darken the first DEAD_CYC cycles of every slot (anti-ghosting).
module smg_scan_mux #(
    parameter int  DIGITS          = 6,
    parameter int  T_DIGIT         = 50000,
    parameter int  DEAD_CYC        = 2,
    parameter int  SCAN_ACTIVE_LOW = 1,
    parameter int  SEG_ACTIVE_LOW  = 1,
    localparam int IW              = $clog2(DIGITS)
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  Enable,
    input  logic [2:0]            Bright,
    input  logic [DIGITS-1:0]     Blank_Mask,
    input  logic [8*DIGITS-1:0]   Seg_In,
    output logic [DIGITS-1:0]     Scan_Sig,
    output logic [7:0]            Seg_Out,
    output logic [IW-1:0]         Digit_Idx,
    output logic                  Frame_Tick
);

    localparam int                CW       = $clog2(T_DIGIT);
    localparam int                OW       = CW + 1;
    localparam int                WIN_LEN  = T_DIGIT / 8;
    localparam logic [DIGITS-1:0] SCAN_OFF = {DIGITS{SCAN_ACTIVE_LOW != 0}};
    localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW != 0}};

    if (DIGITS < 2 || DIGITS > 16 || T_DIGIT < 16 || (T_DIGIT % 8) != 0 ||
        DEAD_CYC >= WIN_LEN) begin : g_param_check
        $error("smg_scan_mux: illegal parameter set");
    end

    logic [CW-1:0]     c_cnt, c_nxt;
    logic [IW-1:0]     i_cnt, i_nxt;
    logic [2:0]        bl, bl_nxt;
    logic              c_last, i_last;
    logic [OW-1:0]     on_len;
    logic              in_win, dead_ok;
    logic              blank_sel, shown;
    logic [7:0]        seg_sel;
    logic [DIGITS-1:0] scan_sel;
    logic [DIGITS-1:0] scan_nxt;
    logic [7:0]        seg_nxt;
    logic [IW-1:0]     idx_nxt;
    logic              tick_nxt;

    assign c_last = (c_cnt == CW'(T_DIGIT - 1));
    assign i_last = (i_cnt == IW'(DIGITS - 1));
    assign on_len = OW'((int'(bl) + 1) * WIN_LEN);

`ifdef SMG_SCAN_DEADTIME_EN
    assign dead_ok = (c_cnt >= CW'(DEAD_CYC));
`else
    assign dead_ok = 1'b1;
`endif

    assign in_win = dead_ok && ({1'b0, c_cnt} < on_len);

    // State register; outputs are registered alongside so every output lags the counters by one cycle.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            c_cnt      <= '0;
            i_cnt      <= '0;
            bl         <= 3'd7;
            Scan_Sig   <= SCAN_OFF;
            Seg_Out    <= SEG_OFF;
            Digit_Idx  <= '0;
            Frame_Tick <= 1'b0;
        end else begin
            c_cnt      <= c_nxt;
            i_cnt      <= i_nxt;
            bl         <= bl_nxt;
            Scan_Sig   <= scan_nxt;
            Seg_Out    <= seg_nxt;
            Digit_Idx  <= idx_nxt;
            Frame_Tick <= tick_nxt;
        end
    end

    // Brightness is only picked up at the slot boundary so a slot never changes duty mid-way.
    always_comb begin
        c_nxt  = '0;
        i_nxt  = '0;
        bl_nxt = bl;
        if (c_last) begin
            bl_nxt = Bright;
        end
        if (Enable) begin
            c_nxt = c_last ? '0 : c_cnt + 1'b1;
            if (c_last) begin
                i_nxt = i_last ? '0 : i_cnt + 1'b1;
            end else begin
                i_nxt = i_cnt;
            end
        end
    end

    always_comb begin
        seg_sel   = SEG_OFF;
        scan_sel  = '0;
        blank_sel = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (i_cnt == IW'(j)) begin
                seg_sel              = Seg_In[8*(DIGITS-1-j) +: 8];
                scan_sel[DIGITS-1-j] = 1'b1;
                blank_sel            = Blank_Mask[j];
            end
        end
    end

    always_comb begin
        shown    = in_win && !blank_sel && Enable;
        scan_nxt = SCAN_OFF;
        seg_nxt  = SEG_OFF;
        if (shown) begin
            scan_nxt = (SCAN_ACTIVE_LOW != 0) ? ~scan_sel : scan_sel;
            seg_nxt  = seg_sel;
        end
        idx_nxt  = Enable ? i_cnt : '0;
        tick_nxt = Enable && c_last && i_last;
    end

endmodule
